// File: rtl/arb_pkg.sv
// Shared types and limits for the round-robin / fixed-priority arbiter.
// Imported by the picker and the arbiter top.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

    localparam int ARB_MAX_N = 32;

endpackage : arb_pkg

// File: rtl/arb_pick.sv
// Combinational winner picker: first set request at or after start_idx (rotating), or lowest index in fixed mode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the winner is consumed.
module arb_pick
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start_idx,
    input  arb_mode_e        mode,
    output logic [N-1:0]     win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    logic [IDX_W-1:0] base;

    assign base = (mode == ARB_RR && N > 1) ? start_idx : '0;

    // Priority chain: once a winner is found, later positions are masked off.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] pos;
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        sum        = '0;
        pos        = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, base} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            pos = sum[IDX_W-1:0];
            if (!win_valid && req[pos]) begin
                win_valid       = 1'b1;
                win_idx         = pos;
                win_onehot[pos] = 1'b1;
            end
        end
    end

endmodule : arb_pick

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter, fixed priority or round-robin; owner holds until release or request drop.
// Latency: grant 1 cycle after request in IDLE; one IDLE bubble between consecutive grants.
// Backpressure: none; other requests wait while owned. ARB_HOLD_TIMEOUT_EN adds a forced release after MAX_HOLD cycles.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDX_W    = (N > 1) ? $clog2(N) : 1,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_rr,
    input  logic [N-1:0]     req,
    // "release" is a reserved word in SystemVerilog, hence the owner_ prefix.
    input  logic             owner_release,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             idle_empty,
    output logic             timeout
);

    if (N < 1 || N > ARB_MAX_N || MAX_HOLD < 1) begin : g_param_check
        $error("rr_priority_arbiter: illegal N or MAX_HOLD");
    end

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_d;
    logic [IDX_W-1:0] gnt_idx_d;
    logic             gnt_valid_d;
    logic             idle_empty_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [IDX_W-1:0] start_idx;
    logic [N-1:0]     win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             exit_req;
    logic             expired;
    arb_mode_e        mode;

    assign start_idx = (last_idx_q == IDX_W'(N-1)) ? '0 : last_idx_q + IDX_W'(1);
    assign mode      = mode_rr ? ARB_RR : ARB_FIXED;
    assign exit_req  = owner_release | ~req[gnt_idx];

    arb_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .start_idx  (start_idx),
        .mode       (mode),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;

    // Fires on the GRANT cycle that completes MAX_HOLD cycles of ownership.
    assign expired = (state_q == ARB_GRANT) &&
                     ((hold_cnt_q + HOLD_W'(1)) == HOLD_W'(MAX_HOLD));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == ARB_IDLE) begin
            hold_cnt_d = '0;
        end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            timeout_d  = expired & ~exit_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt;
        gnt_idx_d    = gnt_idx;
        gnt_valid_d  = gnt_valid;
        last_idx_d   = last_idx_q;
        idle_empty_d = (state_q == ARB_IDLE) && (req == '0);
        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_d     = ARB_GRANT;
                    gnt_d       = win_onehot;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    last_idx_d  = win_idx;
                end else begin
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            ARB_GRANT: begin
                if (exit_req || expired) begin
                    state_d     = ARB_IDLE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gnt        <= '0;
            gnt_idx    <= '0;
            gnt_valid  <= 1'b0;
            idle_empty <= 1'b1;
            last_idx_q <= IDX_W'(N-1);
        end else begin
            state_q    <= state_d;
            gnt        <= gnt_d;
            gnt_idx    <= gnt_idx_d;
            gnt_valid  <= gnt_valid_d;
            idle_empty <= idle_empty_d;
            last_idx_q <= last_idx_d;
        end
    end

endmodule : rr_priority_arbiter

// File: tb/tb_rr_priority_arbiter.sv
// Directed self-checking bench for rr_priority_arbiter (N=4, MAX_HOLD=4).
module tb_rr_priority_arbiter;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode_rr;
    logic [N-1:0]     req;
    logic             owner_release;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             idle_empty;
    logic             timeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_priority_arbiter #(
        .N        (N),
        .IDX_W    (IDX_W),
        .MAX_HOLD (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_rr       (mode_rr),
        .req           (req),
        .owner_release (owner_release),
        .gnt           (gnt),
        .gnt_idx       (gnt_idx),
        .gnt_valid     (gnt_valid),
        .idle_empty    (idle_empty),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        owner_release = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode_rr = 1'b0;
        req = '0;
        owner_release = 1'b0;
        #2;
        n_checks++;
        if ({gnt, gnt_idx, gnt_valid, idle_empty, timeout} !== {4'b0000, 2'd0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b idx=%0d vld=%b idle=%b tmo=%b, need gnt=0000 idx=0 vld=0 idle=1 tmo=0",
                     gnt, gnt_idx, gnt_valid, idle_empty, timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed();
        do_reset();
        mode_rr = 1'b0;
        req = 4'b0110;
        @(negedge clk);
        n_checks++;
        if ({gnt, gnt_idx, gnt_valid, idle_empty} !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL fixed_grant: gnt=%b idx=%0d vld=%b idle=%b, need 0010 1 1 0", gnt, gnt_idx, gnt_valid, idle_empty);
        end
        owner_release = 1'b1;
        @(negedge clk);
        owner_release = 1'b0;
        n_checks++;
        if ({gnt, gnt_valid} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL fixed_release: gnt=%b vld=%b, need 0000 0", gnt, gnt_valid);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp_gnt;
        do_reset();
        mode_rr = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            exp_gnt = 4'b0001 << order[i];
            n_checks++;
            if (gnt !== exp_gnt || gnt_idx !== IDX_W'(order[i]) || gnt_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: gnt=%b idx=%0d vld=%b, need %b %0d 1", i, gnt, gnt_idx, gnt_valid, exp_gnt, order[i]);
            end
            owner_release = 1'b1;
            @(negedge clk);
            owner_release = 1'b0;
            n_checks++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_bubble[%0d]: gnt=%b vld=%b, need 0000 0", i, gnt, gnt_valid);
            end
            @(negedge clk);
        end
        req = '0;
        owner_release = 1'b1;
        @(negedge clk);
        owner_release = 1'b0;
    endtask

    task automatic test_idle();
        do_reset();
        mode_rr = 1'b0;
        req = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({gnt, gnt_valid, idle_empty} !== {4'b0000, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL idle_empty[%0d]: gnt=%b vld=%b idle=%b, need 0000 0 1", i, gnt, gnt_valid, idle_empty);
            end
        end
        req = 4'b1000;
        @(negedge clk);
        n_checks++;
        if ({gnt, gnt_idx, idle_empty} !== {4'b1000, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_then_req: gnt=%b idx=%0d idle=%b, need 1000 3 0", gnt, gnt_idx, idle_empty);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        mode_rr = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL arst_setup: gnt=%b idx=%0d, need 0100 2", gnt, gnt_idx);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({gnt, gnt_valid, idle_empty} !== {4'b0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL arst_immediate: gnt=%b vld=%b idle=%b, need 0000 0 1", gnt, gnt_valid, idle_empty);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL arst_first_grant: gnt=%b idx=%0d, need 0001 0", gnt, gnt_idx);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_req_drop();
        do_reset();
        mode_rr = 1'b0;
        req = 4'b0010;
        @(negedge clk);
        req = 4'b1010;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_hold: gnt=%b, need 0010", gnt);
        end
        req = 4'b1000;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_clear: gnt=%b vld=%b, need 0000 0", gnt, gnt_valid);
        end
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL drop_regrant: gnt=%b idx=%0d, need 1000 3", gnt, gnt_idx);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_hold();
        do_reset();
        mode_rr = 1'b0;
        req = 4'b0001;
        @(negedge clk);
`ifdef ARB_HOLD_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: gnt=%b tmo=%b, need 0001 0", i, gnt, timeout);
            end
            @(negedge clk);
        end
        n_checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_timeout: gnt=%b tmo=%b, need 0000 1", gnt, timeout);
        end
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_regrant: gnt=%b tmo=%b, need 0001 0", gnt, timeout);
        end
`else
        for (int i = 0; i < 50; i++) begin
            n_checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_forever[%0d]: gnt=%b tmo=%b, need 0001 0", i, gnt, timeout);
            end
            @(negedge clk);
        end
`endif
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_idle();
        test_async_reset();
        test_req_drop();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rr_priority_arbiter
